prim_flop_pipe: RTL and testbench

Parametrised elastic register pipeline: `Depth` stages of `Width`-bit enabled flops, each stage with a valid bit, linked by a valid/ready handshake and clearable by a synchronous flush. It is the handshaked, multi-stage successor to the single enabled flop primitive. It is used wherever a datapath needs registered retiming with back-pressure, for example between the AXI-Lite front end and the QSPI sequencer. Occupancy is exported for debug and drain checks.

---
 rtl/prim_flop_pipe_pkg.sv | 24 ++
 rtl/prim_flop_pipe_stage.sv | 53 +++++
 rtl/prim_flop_pipe.sv | 107 ++++++++++
 tb/tb_prim_flop_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_flop_pipe_pkg.sv
// Shared definitions for the elastic flop pipeline: count-width helper and
// the per-cycle transfer classification used by the occupancy counter.
package prim_flop_pipe_pkg;

    // What happened at the pipeline boundary this cycle.
    // Bit 0 = input transfer, bit 1 = output transfer.
    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_IN   = 2'b01,
        XFER_OUT  = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    // Width needed to hold an occupancy value in 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Classify the boundary handshakes into a single transfer kind.
    function automatic xfer_e xfer_kind(input logic in_xfer, input logic out_xfer);
        return xfer_e'({out_xfer, in_xfer});
    endfunction

endpackage : prim_flop_pipe_pkg

// File: rtl/prim_flop_pipe_stage.sv
// One pipeline stage: a valid bit and an enabled data flop.
// The stage loads whenever its load enable (the "free" term for this stage,
// computed by the parent from the downstream chain) is high. A bubble loaded
// from upstream clears the valid bit but leaves the data register untouched.
module prim_flop_pipe_stage
    import prim_flop_pipe_pkg::*;
#(
    parameter int unsigned       Width      = 8,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             up_valid_i,
    input  logic [Width-1:0] up_data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] data_d,  data_q;

    // Next state: flush wins over any load; data only moves with a valid word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = ResetValue;
        end else if (load_i) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= ResetValue;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : prim_flop_pipe_stage

// File: rtl/prim_flop_pipe.sv
// Elastic register pipeline of Depth stages with valid/ready handshakes,
// synchronous flush and a registered occupancy count.
//
// Handshake rule: a word moves across a boundary on a rising edge exactly
// when valid and ready are both high in the cycle before that edge. Ready
// may depend combinationally on the downstream ready; valid never depends
// on ready. Once a stage holds a word it keeps it until it is taken.
module prim_flop_pipe
    import prim_flop_pipe_pkg::*;
#(
    parameter int unsigned      Width      = 8,
    parameter int unsigned      Depth      = 2,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter int unsigned      CntW       = cnt_width(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [CntW-1:0]  count_o
);

    // free[k]: stage k may load this cycle. free[Depth] is the downstream port.
    logic [Depth:0]   free;
    logic [Depth-1:0] valid;
    logic [Width-1:0] data [Depth];

    logic             in_xfer;
    logic             out_xfer;
    xfer_e            xfer;
    logic [CntW-1:0]  count_d, count_q;

    // Ready chain, evaluated output-to-input in one block so the whole
    // combinational path is a single ripple from out_ready_i.
    always_comb begin
        free        = '0;
        free[Depth] = out_ready_i;
        for (int k = int'(Depth) - 1; k >= 0; k--) begin
            free[k] = ~valid[k] | free[k+1];
        end
    end

    for (genvar k = 0; k < Depth; k++) begin : g_stage
        logic             up_valid;
        logic [Width-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = in_valid_i;
            assign up_data  = in_data_i;
        end else begin : g_link
            assign up_valid = valid[k-1];
            assign up_data  = data[k-1];
        end

        prim_flop_pipe_stage #(
            .Width      (Width),
            .ResetValue (ResetValue)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .load_i     (free[k]),
            .up_valid_i (up_valid),
            .up_data_i  (up_data),
            .valid_o    (valid[k]),
            .data_o     (data[k])
        );
    end

    assign in_ready_o  = free[0] & ~flush_i;
    assign out_valid_o = valid[Depth-1];
    assign out_data_o  = data[Depth-1];

    // Occupancy next value: +1 on accept, -1 on emit, cleared by flush.
    always_comb begin
        in_xfer  = in_valid_i & in_ready_o;
        out_xfer = out_valid_o & out_ready_i;
        xfer     = xfer_kind(in_xfer, out_xfer);
        count_d  = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case (xfer)
                XFER_IN:  count_d = count_q + CntW'(1);
                XFER_OUT: count_d = count_q - CntW'(1);
                default:  count_d = count_q;
            endcase
        end
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : prim_flop_pipe

// File: tb/tb_prim_flop_pipe.sv
// Bench for prim_flop_pipe: three instances (Depth 3, 4 and 1) share one
// stimulus stream. A queue-of-words model with per-word accept times gives
// the expected ready, valid, data and occupancy for each instance; a vector
// table and short hand sequences pin exact values on the Depth=3 instance.
module tb_prim_flop_pipe;

    localparam logic [7:0] RV = 8'h5A;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;

    logic       ir_3, ov_3, ir_4, ov_4, ir_1, ov_1;
    logic [7:0] od_3, od_4, od_1;
    logic [1:0] cnt_3;
    logic [2:0] cnt_4;
    logic [0:0] cnt_1;

    prim_flop_pipe #(.Width(8), .Depth(3), .ResetValue(RV)) u_d3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir_3), .in_data_i(in_data),
        .out_valid_o(ov_3), .out_ready_i(out_ready), .out_data_o(od_3),
        .count_o(cnt_3)
    );

    prim_flop_pipe #(.Width(8), .Depth(4), .ResetValue(RV)) u_d4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir_4), .in_data_i(in_data),
        .out_valid_o(ov_4), .out_ready_i(out_ready), .out_data_o(od_4),
        .count_o(cnt_4)
    );

    prim_flop_pipe #(.Width(8), .Depth(1), .ResetValue(RV)) u_d1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir_1), .in_data_i(in_data),
        .out_valid_o(ov_1), .out_ready_i(out_ready), .out_data_o(od_1),
        .count_o(cnt_1)
    );

    // scoreboard state
    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;
    int cyc = 0;

    // per-instance word buffers: data and the edge number it was accepted on
    logic [7:0] m_data [3][16];
    int         m_acc  [3][16];
    int         m_rd   [3] = '{0, 0, 0};
    int         m_wr   [3] = '{0, 0, 0};

    function automatic int dep_of(input int s);
        case (s)
            0:       return 3;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] get_ir(input int s);
        case (s)
            0:       return 32'(ir_3);
            1:       return 32'(ir_4);
            default: return 32'(ir_1);
        endcase
    endfunction

    function automatic logic [31:0] get_ov(input int s);
        case (s)
            0:       return 32'(ov_3);
            1:       return 32'(ov_4);
            default: return 32'(ov_1);
        endcase
    endfunction

    function automatic logic [31:0] get_od(input int s);
        case (s)
            0:       return 32'(od_3);
            1:       return 32'(od_4);
            default: return 32'(od_1);
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int s);
        case (s)
            0:       return 32'(cnt_3);
            1:       return 32'(cnt_4);
            default: return 32'(cnt_1);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Model: a pipe of depth d holding n words accepts unless it is full and
    // stalled; the oldest word reaches the output d-1 edges after its accept.
    task automatic model_check(input int s, output bit ir, output bit ov);
        int n;
        int d;
        n  = m_wr[s] - m_rd[s];
        d  = dep_of(s);
        ir = !flush && ((n < d) || out_ready);
        ov = (n > 0) && ((cyc - m_acc[s][m_rd[s] & 15]) >= d - 1);
        if (checking) begin
            check($sformatf("d%0d in_ready", d), get_ir(s), 32'(ir));
            check($sformatf("d%0d out_valid", d), get_ov(s), 32'(ov));
            check($sformatf("d%0d count", d), get_cnt(s), 32'(n));
            if (ov) begin
                check($sformatf("d%0d out_data", d), get_od(s), 32'(m_data[s][m_rd[s] & 15]));
            end
        end
    endtask

    // driver: inputs are already applied; check, clock, advance the model
    task automatic cycle();
        bit ir [3];
        bit ov [3];
        #2;
        for (int s = 0; s < 3; s++) begin
            model_check(s, ir[s], ov[s]);
        end
        @(posedge clk);
        cyc++;
        for (int s = 0; s < 3; s++) begin
            if (rst || flush) begin
                m_rd[s] = m_wr[s];
            end else begin
                if (ov[s] && out_ready) m_rd[s]++;
                if (in_valid && ir[s]) begin
                    m_data[s][m_wr[s] & 15] = in_data;
                    m_acc[s][m_wr[s] & 15]  = cyc;
                    m_wr[s]++;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit f, input bit iv, input logic [7:0] d, input bit r);
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = r;
    endtask

    typedef struct {
        bit         flush;
        bit         iv;
        logic [7:0] din;
        bit         ordy;
        bit         e_ir;
        bit         e_ov;
        bit         chk_d;
        logic [7:0] e_d;
        int         e_cnt;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input bit f, input bit iv, input logic [7:0] d, input bit r,
                                input bit eir, input bit eov, input bit cd,
                                input logic [7:0] ed, input int ec);
        vec_t v;
        v.flush = f;   v.iv = iv;   v.din = d;    v.ordy = r;
        v.e_ir  = eir; v.e_ov = eov; v.chk_d = cd; v.e_d = ed; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        // back-to-back stream with out_ready=1
        tbl[0]  = mk(0, 1, 8'h11, 1,  1, 0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 1, 8'h22, 1,  1, 0, 0, 8'h00, 1);
        tbl[2]  = mk(0, 1, 8'h33, 1,  1, 0, 0, 8'h00, 2);
        tbl[3]  = mk(0, 0, 8'h00, 1,  1, 1, 1, 8'h11, 3);
        tbl[4]  = mk(0, 0, 8'h00, 1,  1, 1, 1, 8'h22, 2);
        tbl[5]  = mk(0, 0, 8'h00, 1,  1, 1, 1, 8'h33, 1);
        tbl[6]  = mk(0, 0, 8'h00, 1,  1, 0, 1, 8'h33, 0);
        // back-pressure: five offered, three accepted, then release
        tbl[7]  = mk(0, 1, 8'h01, 0,  1, 0, 0, 8'h00, 0);
        tbl[8]  = mk(0, 1, 8'h02, 0,  1, 0, 0, 8'h00, 1);
        tbl[9]  = mk(0, 1, 8'h03, 0,  1, 0, 0, 8'h00, 2);
        tbl[10] = mk(0, 1, 8'h04, 0,  0, 1, 1, 8'h01, 3);
        tbl[11] = mk(0, 1, 8'h05, 0,  0, 1, 1, 8'h01, 3);
        tbl[12] = mk(0, 0, 8'h00, 1,  1, 1, 1, 8'h01, 3);
        tbl[13] = mk(0, 0, 8'h00, 1,  1, 1, 1, 8'h02, 2);
        tbl[14] = mk(0, 0, 8'h00, 1,  1, 1, 1, 8'h03, 1);
        tbl[15] = mk(0, 0, 8'h00, 1,  1, 0, 1, 8'h03, 0);
        // fill, then full pipe streaming at one word per cycle
        tbl[16] = mk(0, 1, 8'h41, 0,  1, 0, 0, 8'h00, 0);
        tbl[17] = mk(0, 1, 8'h42, 0,  1, 0, 0, 8'h00, 1);
        tbl[18] = mk(0, 1, 8'h43, 0,  1, 0, 0, 8'h00, 2);
        tbl[19] = mk(0, 1, 8'h44, 1,  1, 1, 1, 8'h41, 3);
        tbl[20] = mk(0, 1, 8'h45, 1,  1, 1, 1, 8'h42, 3);
        tbl[21] = mk(0, 1, 8'h46, 1,  1, 1, 1, 8'h43, 3);
        tbl[22] = mk(0, 0, 8'h00, 0,  0, 1, 1, 8'h44, 3);
        // drop to two words, then flush with an offered input
        tbl[23] = mk(0, 0, 8'h00, 1,  1, 1, 1, 8'h44, 3);
        tbl[24] = mk(1, 1, 8'h77, 0,  0, 1, 1, 8'h45, 2);
        tbl[25] = mk(0, 0, 8'h00, 0,  1, 0, 1, RV,    0);

        // reset
        rst = 1'b1;
        drive(0, 0, 8'h00, 0);
        cycle();
        cycle();
        rst = 1'b0;
        checking = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst d%0d out_valid", dep_of(s)), get_ov(s), 32'd0);
            check($sformatf("rst d%0d out_data", dep_of(s)), get_od(s), 32'(RV));
            check($sformatf("rst d%0d count", dep_of(s)), get_cnt(s), 32'd0);
            check($sformatf("rst d%0d in_ready", dep_of(s)), get_ir(s), 32'd1);
        end

        // vector table on the Depth=3 instance
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].flush, tbl[i].iv, tbl[i].din, tbl[i].ordy);
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(ir_3), 32'(tbl[i].e_ir));
            check($sformatf("vec%0d out_valid", i), 32'(ov_3), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d count", i), 32'(cnt_3), 32'(tbl[i].e_cnt));
            if (tbl[i].chk_d) begin
                check($sformatf("vec%0d out_data", i), 32'(od_3), 32'(tbl[i].e_d));
            end
            cycle();
        end

        // reset with a full pipe and live handshakes on both sides
        drive(0, 1, 8'h91, 0); cycle();
        drive(0, 1, 8'h92, 0); cycle();
        drive(0, 1, 8'h93, 0); cycle();
        check("full before rst count", 32'(cnt_3), 32'd3);
        rst = 1'b1;
        drive(0, 1, 8'h94, 1);
        cycle();
        rst = 1'b0;
        drive(0, 0, 8'h00, 1);
        #1;
        check("post-rst out_valid", 32'(ov_3), 32'd0);
        check("post-rst out_data", 32'(od_3), 32'(RV));
        check("post-rst count", 32'(cnt_3), 32'd0);
        check("post-rst in_ready", 32'(ir_3), 32'd1);
        drive(0, 1, 8'hB1, 1);
        cycle();
        drive(0, 0, 8'h00, 1);
        #1;
        check("post-rst word edge1 out_valid", 32'(ov_3), 32'd0);
        check("post-rst word edge1 count", 32'(cnt_3), 32'd1);
        cycle();
        #1;
        check("post-rst word edge2 out_valid", 32'(ov_3), 32'd0);
        cycle();
        #1;
        check("post-rst word edge3 out_valid", 32'(ov_3), 32'd1);
        check("post-rst word edge3 out_data", 32'(od_3), 32'hB1);
        cycle();

        // random valid/ready traffic with occasional flush and reset
        for (int i = 0; i < 1000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(!rst && ($urandom_range(0, 49) == 0),
                  $urandom_range(0, 3) != 0,
                  8'($urandom),
                  (i < 500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0));
            cycle();
        end

        // drain
        rst = 1'b0;
        drive(0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) cycle();
        #1;
        check("drained d3 count", 32'(cnt_3), 32'd0);
        check("drained d4 count", 32'(cnt_4), 32'd0);
        check("drained d1 count", 32'(cnt_1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prim_flop_pipe
